// File: rtl/spike_gen_pkg.sv
// spike_gen_pkg: channel-state encoding and shared constants for spike_train_gen.
package spike_gen_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HIGH = 2'd1, ST_LOW = 2'd2} chan_state_t;
    localparam int DEF_SPIKE_LENGTH = 40000;
    localparam int CMD_STOP = 0;
endpackage

// File: rtl/spike_chan.sv
// spike_chan: one spike-train channel (IDLE/HIGH/LOW) with period, count and phase sequencing.
// Optional SPIKE_GEN_DEBUG_CNT_EN adds a free-running 32-bit spike-entry counter.
module spike_chan
    import spike_gen_pkg::*;
#(
    parameter int SPIKE_LENGTH = DEF_SPIKE_LENGTH,
    parameter int PERIOD_W     = 32,
    parameter int COUNT_W      = 16
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [COUNT_W-1:0]  count,
    output logic                spike,
    output logic                busy,
    output logic                done,
    output logic [31:0]         spike_total
);
    localparam logic [PERIOD_W-1:0] HIGH_LAST  = PERIOD_W'(SPIKE_LENGTH - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(SPIKE_LENGTH + 1);
    chan_state_t state, state_n;
    logic [PERIOD_W-1:0] cnt, low_last, eff_period;
    logic [COUNT_W-1:0]  remaining;
    logic                counted, phase_end, last;
    assign eff_period = period < MIN_PERIOD ? MIN_PERIOD : period;
    assign phase_end  = cnt == (state == ST_HIGH ? HIGH_LAST : low_last);
    // final low cycle of a counted train: busy drops and done pulses here
    assign last = state == ST_LOW && phase_end && counted && remaining == '0;

    always_ff @(posedge sys_clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= state_n;

    always_comb begin
        state_n = stop ? ST_IDLE :
                  start ? ST_HIGH :
                  (!phase_end || state == ST_IDLE) ? state :
                  state == ST_HIGH ? ST_LOW :
                  last ? ST_IDLE : ST_HIGH;
    end

    always_comb begin
        spike = state == ST_HIGH;
        busy  = state != ST_IDLE && !last;
        done  = last;
    end

    always_ff @(posedge sys_clk or posedge rst)
        if (rst) begin
            cnt       <= '0;
            low_last  <= '0;
            remaining <= '0;
            counted   <= 1'b0;
        end else begin
            cnt <= (start || state_n != state || state_n == ST_IDLE) ? '0 : cnt + PERIOD_W'(1);
            if (start) begin
                low_last  <= eff_period - MIN_PERIOD;
                remaining <= count;
                counted   <= count != '0;
            end else if (state == ST_HIGH && phase_end && counted)
                remaining <= remaining - COUNT_W'(1);
        end

`ifdef SPIKE_GEN_DEBUG_CNT_EN
    always_ff @(posedge sys_clk or posedge rst)
        if (rst) spike_total <= '0;
        else if (state_n == ST_HIGH && state != ST_HIGH) spike_total <= spike_total + 32'd1;
`else
    assign spike_total = '0;
`endif
endmodule

// File: rtl/spike_train_gen.sv
// spike_train_gen: command decode and handshake for NUM_OUTPUTS spike_chan channels.
// Optional SPIKE_GEN_DEBUG_CNT_EN enables per-channel spike totals on debug_spike_counter.
module spike_train_gen
    import spike_gen_pkg::*;
#(
    parameter int NUM_OUTPUTS  = 6,
    parameter int SPIKE_LENGTH = DEF_SPIKE_LENGTH,
    parameter int PERIOD_W     = 32,
    parameter int COUNT_W      = 16
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_chan,
    input  logic [PERIOD_W-1:0]       cmd_period,
    input  logic [COUNT_W-1:0]        cmd_count,
    output logic [NUM_OUTPUTS-1:0]    o_spike,
    output logic [NUM_OUTPUTS-1:0]    busy,
    output logic [NUM_OUTPUTS-1:0]    done,
    output logic                      err,
    output logic [NUM_OUTPUTS*32-1:0] debug_spike_counter
);
    logic [7:0] busy_pad;
    logic       invalid, is_stop, fire;
    assign busy_pad  = 8'(busy);
    assign invalid   = 32'(cmd_chan) >= NUM_OUTPUTS;
    assign is_stop   = cmd_period == PERIOD_W'(CMD_STOP);
    assign cmd_ready = !rst && (invalid || is_stop || !busy_pad[cmd_chan]);
    assign fire      = cmd_valid && cmd_ready;

    always_ff @(posedge sys_clk or posedge rst)
        if (rst) err <= 1'b0;
        else err <= fire && invalid;

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_chan
        logic sel;
        assign sel = fire && cmd_chan == 3'(i);
        spike_chan #(
            .SPIKE_LENGTH(SPIKE_LENGTH),
            .PERIOD_W    (PERIOD_W),
            .COUNT_W     (COUNT_W)
        ) u_chan (
            .sys_clk    (sys_clk),
            .rst        (rst),
            .start      (sel && !is_stop),
            .stop       (sel && is_stop),
            .period     (cmd_period),
            .count      (cmd_count),
            .spike      (o_spike[i]),
            .busy       (busy[i]),
            .done       (done[i]),
            .spike_total(debug_spike_counter[i*32 +: 32])
        );
    end
endmodule

// File: tb/tb_spike_train_gen.sv
// tb_spike_train_gen: directed and randomized checks of spike_train_gen against an arithmetic train model.
`timescale 1ns/1ps
module tb_spike_train_gen;
    localparam int N = 6, SL = 3, PW = 32, CW = 16;
    logic          sys_clk = 0, rst = 0, cmd_valid = 0, cmd_ready, err;
    logic [2:0]    cmd_chan = 0;
    logic [PW-1:0] cmd_period = 0;
    logic [CW-1:0] cmd_count = 0;
    logic [N-1:0]  o_spike, busy, done;
    logic [N*32-1:0] debug_spike_counter;
    int checks = 0, errors = 0, cyc = 0;
    bit chk_en = 0, err_exp = 0, m_fire;
    bit act [N];
    int t0 [N], eff [N], n [N], base [N];
    logic [N-1:0] es, eb, ed;
    logic [31:0] edbg;

    spike_train_gen #(.NUM_OUTPUTS(N), .SPIKE_LENGTH(SL), .PERIOD_W(PW), .COUNT_W(CW)) dut (
        .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_period(cmd_period), .cmd_count(cmd_count),
        .o_spike(o_spike), .busy(busy), .done(done), .err(err),
        .debug_spike_counter(debug_spike_counter)
    );

    always #5 sys_clk = ~sys_clk;

    // train model: cycle k after acceptance sits at phase k%eff of spike k/eff
    function automatic int kk(int ch, int t);
        return t - t0[ch] - 1;
    endfunction
    function automatic bit m_spike(int ch, int t);
        int k;
        if (!act[ch]) return 0;
        k = kk(ch, t);
        return k >= 0 && (n[ch] == 0 || k < n[ch] * eff[ch]) && (k % eff[ch]) < SL;
    endfunction
    function automatic bit m_busy(int ch, int t);
        if (!act[ch]) return 0;
        return n[ch] == 0 || kk(ch, t) < n[ch] * eff[ch] - 1;
    endfunction
    function automatic bit m_done(int ch, int t);
        return act[ch] && n[ch] != 0 && kk(ch, t) == n[ch] * eff[ch] - 1;
    endfunction
    function automatic int m_emitted(int ch, int t);
        int k, e;
        if (!act[ch]) return 0;
        k = kk(ch, t);
        if (k < 0) return 0;
        e = k / eff[ch] + 1;
        return (n[ch] != 0 && e > n[ch]) ? n[ch] : e;
    endfunction
    function automatic bit m_ready(int ch, int per, int t);
        return ch >= N || per == 0 || !m_busy(ch, t);
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge sys_clk) begin
        if (rst) begin
            cyc = 0;
            err_exp = 0;
            for (int c = 0; c < N; c++) begin
                act[c] = 0;
                base[c] = 0;
            end
        end else begin
            m_fire = cmd_valid && m_ready(int'(cmd_chan), int'(cmd_period), cyc);
            err_exp = m_fire && cmd_chan >= N;
            if (m_fire && cmd_chan < N) begin
                base[cmd_chan] += m_emitted(int'(cmd_chan), cyc);
                if (cmd_period == 0) act[cmd_chan] = 0;
                else begin
                    act[cmd_chan] = 1;
                    t0[cmd_chan]  = cyc;
                    eff[cmd_chan] = (int'(cmd_period) < SL + 1) ? SL + 1 : int'(cmd_period);
                    n[cmd_chan]   = int'(cmd_count);
                end
            end
            cyc++;
        end
    end

    always @(negedge sys_clk) if (chk_en) begin
        for (int c = 0; c < N; c++) begin
            es[c] = m_spike(c, cyc);
            eb[c] = m_busy(c, cyc);
            ed[c] = m_done(c, cyc);
        end
        check("o_spike", o_spike, es);
        check("busy", busy, eb);
        check("done", done, ed);
        check("err", err, err_exp);
        check("cmd_ready", cmd_ready, !rst && m_ready(int'(cmd_chan), int'(cmd_period), cyc));
        for (int c = 0; c < N; c++) begin
`ifdef SPIKE_GEN_DEBUG_CNT_EN
            edbg = 32'(base[c] + m_emitted(c, cyc));
`else
            edbg = '0;
`endif
            check("debug_spike_counter", debug_spike_counter[c*32 +: 32], edbg);
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic at(int t);
        while (cyc < t) step();
        @(negedge sys_clk);
    endtask

    task automatic send(int ch, int per, int cnt);
        bit acc = 0;
        step();
        cmd_valid = 1;
        cmd_chan = 3'(ch);
        cmd_period = PW'(per);
        cmd_count = CW'(cnt);
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge sys_clk);
            acc = cmd_ready;
            step();
        end
        cmd_valid = 0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: chan %0d never accepted, required within 200 cycles", ch);
        end
    endtask

    initial begin
        int t, exp_dbg;
        logic [7:0] pat;
        #1 rst = 1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset cmd_ready", cmd_ready, 0);
        check("reset o_spike", o_spike, 0);
        check("reset busy", busy, 0);
        check("reset err", err, 0);
        step();
        rst = 0;
        chk_en = 1;
        @(negedge sys_clk);
        check("release cmd_ready", cmd_ready, 1);

        send(2, 10, 2);
        t = cyc - 1;
        at(t + 1);
        check("s1 spike c1", o_spike[2], 1);
        check("s1 others", o_spike & ~6'b000100, 0);
        at(t + 3);  check("s1 spike c3", o_spike[2], 1);
        at(t + 4);  check("s1 low c4", o_spike[2], 0);
        at(t + 10); check("s1 low c10", o_spike[2], 0);
        at(t + 11); check("s1 spike c11", o_spike[2], 1);
        at(t + 19); check("s1 busy c19", busy[2], 1);
        at(t + 20); check("s1 done c20", done[2], 1); check("s1 busy c20", busy[2], 0);
        at(t + 21); check("s1 done c21", done[2], 0);

        send(0, 2, 0);
        t = cyc - 1;
        pat = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            at(t + 1 + k);
            check("s2 pattern", o_spike[0], pat[k]);
        end
        step();
        cmd_valid = 1; cmd_chan = 0; cmd_period = 5; cmd_count = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            check("s2 held ready", cmd_ready, 0);
            step();
        end
        cmd_valid = 0;
        send(0, 0, 0);
        at(cyc);
        check("s2 stopped busy", busy[0], 0);

        send(1, 6, 0);
        step();
        cmd_valid = 1; cmd_chan = 1; cmd_period = 0; cmd_count = 0;
        @(negedge sys_clk);
        check("s3 stop ready", cmd_ready, 1);
        check("s3 mid spike", o_spike[1], 1);
        step();
        cmd_valid = 0;
        @(negedge sys_clk);
        check("s3 spike dropped", o_spike[1], 0);
        check("s3 busy dropped", busy[1], 0);
        check("s3 no done", done[1], 0);

        send(7, 5, 1);
        at(cyc);
        check("s4 err pulse", err, 1);
        check("s4 no output", o_spike, 0);
        at(cyc + 1);
        check("s4 err cleared", err, 0);

        send(4, 4, 5);
        t = cyc - 1;
        at(t + 20); check("s5 done", done[4], 1);
        at(t + 21);
`ifdef SPIKE_GEN_DEBUG_CNT_EN
        exp_dbg = 5;
`else
        exp_dbg = 0;
`endif
        check("s5 debug count", debug_spike_counter[4*32 +: 32], 32'(exp_dbg));

        send(0, 8, 0);
        send(3, 8, 0);
        #2 chk_en = 0;
        rst = 1;
        #1 check("s6 async spike", o_spike, 0);
        check("s6 async busy", busy, 0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge sys_clk);
        check("s6 ready after reset", cmd_ready, 1);
        check("s6 idle after reset", busy, 0);

        for (int i = 0; i < 1200; i++) begin
            step();
            cmd_valid  = $urandom_range(0, 2) == 0;
            cmd_chan   = 3'($urandom_range(0, 7));
            cmd_period = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(1, 12));
            cmd_count  = CW'($urandom_range(0, 3));
        end
        step();
        cmd_valid = 0;
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
